wallace_cpa_accumulator: RTL
============================

Name: wallace_cpa_accumulator

Overview:
- Consumer end of the Wallace partial-product compressor in the conv1d datapath.
- Takes the redundant carry/sum vector pair for each product, resolves it with a 2-stage pipelined carry-propagate adder, and accumulates products across a kernel window marked by first/last flags.
- On each window's last tap, emits a scaled, saturated WIDTH_DATA-bit result through a valid/ready handshake.

Parameters:
- WIDTH_DATA, 16 (from define.v), operand width; carry/sum vectors are 2*WIDTH_DATA bits wide.
- ACC_W, 40, accumulator width in bits; must be >= 2*WIDTH_DATA.
- OUT_SHIFT, 8, arithmetic right shift applied to the accumulator before saturation; range 0..ACC_W-WIDTH_DATA.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_cout  input  2*WIDTH_DATA  compressor carry vector; bit i has weight 2^(i+1)
- in_sum  input  2*WIDTH_DATA  compressor sum vector; bit i has weight 2^i
- in_first  input  1  beat is the first tap of a window
- in_last  input  1  beat is the last tap of a window
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH_DATA  signed scaled, saturated result
- out_acc  output  ACC_W  raw accumulator value captured with out_data
- out_sat  output  1  out_data was clipped

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_acc=0, out_sat=0, accumulator=0, stage-1 valid=0. in_ready=1 in the cycle after reset. A partial window in flight is discarded.
- Product: P = (in_sum + (in_cout << 1)) mod 2^(2W), with W=WIDTH_DATA. in_cout[2W-1] is shifted out and dropped. P is read as signed two's complement and sign-extended to ACC_W.
- Global advance enable: en = !out_valid || out_ready. in_ready = en. When en=0, all pipeline registers hold.
- Stage 1, on the accept edge:
  - register low-half sum L = sum[W-1:0] + (cout<<1)[W-1:0], the carry-out c, both upper halves, first, last, and s1_valid.
  - A non-accept edge with en=1 loads s1_valid=0 (bubble).
- Stage 2, on the next edge with en=1 and s1_valid=1:
  - upper half H = sum_hi + cout_sh_hi + c; P = {H, L}.
  - If first=1: acc <= sext(P). Otherwise: acc <= acc + sext(P), wrapping mod 2^ACC_W.
  - A tap with first=0 and no preceding first accumulates onto the current acc value.
- Output capture, same edge as stage 2 when last=1, using the new acc value N:
  - out_acc <= N.
  - S = N >>> OUT_SHIFT (arithmetic).
  - If S > 2^(W-1)-1: out_data = 0x7FFF (W=16), out_sat = 1.
  - Else if S < -2^(W-1): out_data = 0x8000, out_sat = 1.
  - Else: out_data = S[W-1:0], out_sat = 0.
  - out_valid <= 1.
- first=1 and last=1 on the same beat: a single-tap window; the result is P alone.
- Latency: a beat accepted at edge E0 updates the accumulator, and for a last tap asserts out_valid, at edge E1 (2 cycles from accept to out_valid visible).
- Output handshake:
  - out_valid && out_ready at an edge with no new last capture: out_valid <= 0.
  - Same edge as a new last capture: the new result loads and out_valid stays 1 (back-to-back, no bubble).
  - While out_valid && !out_ready: out_data, out_acc, out_sat are stable and the pipeline stalls.
  - No result is ever dropped or duplicated.
- Flags are ignored on beats that are not accepted.

Test Plan:
- Single tap, OUT_SHIFT=8: sum=0x00000600, cout=0x00000080, first=last=1 -> P=0x700, out_valid 2 cycles after accept, out_data=0x0007, out_acc=0x700, out_sat=0.
- Half-boundary carry: sum=0x0000FFFF, cout=0x00000001, first=last=1 -> P=0x00010001, out_data=0x0100.
- Negative accumulation: 3 taps of sum=0xFFFFFF00, cout=0 (first on tap 1, last on tap 3) -> acc=-768, out_data=0xFFFD, out_sat=0.
- Saturation:
  - 8 taps of sum=0x40000000, cout=0 -> acc=2^33, out_data=0x7FFF, out_sat=1.
  - 8 taps of sum=0xC0000000 -> out_data=0x8000, out_sat=1.
  - cout=0x80000000 alone contributes 0 (dropped MSB).
- Backpressure: two back-to-back single-tap windows (products 0x100, 0x200) with out_ready=0 -> in_ready drops once out_valid=1 and out_data=0x0001 holds. Raise out_ready -> 0x0001 then 0x0002, in order, none lost. Then continuous out_ready=1 -> one result per cycle.
- Reset mid-window: 2 non-last taps accepted, rst pulsed 1 cycle -> out_valid=0, in_ready=1. Then single tap sum=0x00000300 first=last=1 -> out_data=0x0003 (earlier taps discarded).

Source files
------------

// File: rtl/wallace_cpa_accumulator.sv
// wallace_cpa_accumulator: 2-stage carry-propagate resolve of carry/sum pairs, windowed accumulate, scale/saturate out.
module wallace_cpa_accumulator #(
  parameter int WIDTH_DATA = 16,
  parameter int ACC_W      = 40,
  parameter int OUT_SHIFT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*WIDTH_DATA-1:0] in_cout,
  input  logic [2*WIDTH_DATA-1:0] in_sum,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH_DATA-1:0]   out_data,
  output logic [ACC_W-1:0]        out_acc,
  output logic                    out_sat
);
  localparam int W = WIDTH_DATA;
  localparam int PW = 2 * W;
  localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << (W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);
  logic                    w_en;
  logic                    w_accept;
  logic [PW-1:0]           w_csh;
  logic [W:0]              w_lo;
  logic [W-1:0]            w_hi;
  logic [PW-1:0]           w_p;
  logic signed [ACC_W-1:0] w_pext;
  logic signed [ACC_W-1:0] w_new;
  logic signed [ACC_W-1:0] w_s;
  logic                    w_pos;
  logic                    w_neg;
  logic [W-1:0]            r_lo;
  logic                    r_c;
  logic [W-1:0]            r_sum_hi;
  logic [W-1:0]            r_cout_hi;
  logic                    r_first;
  logic                    r_last;
  logic                    r_s1_valid;
  logic [ACC_W-1:0]        r_acc;
  logic                    r_out_valid;
  logic [W-1:0]            r_out_data;
  logic [ACC_W-1:0]        r_out_acc;
  logic                    r_out_sat;
  assign w_en     = !r_out_valid || out_ready;
  assign w_accept = in_valid && w_en;
  assign in_ready = w_en;
  // carry vector bits carry weight 2^(i+1); the MSB falls off the product width
  assign w_csh  = in_cout << 1;
  assign w_lo   = {1'b0, in_sum[W-1:0]} + {1'b0, w_csh[W-1:0]};
  assign w_hi   = r_sum_hi + r_cout_hi + W'(r_c);
  assign w_p    = {w_hi, r_lo};
  assign w_pext = $signed(w_p);
  assign w_new  = r_first ? w_pext : r_acc + w_pext;
  assign w_s    = w_new >>> OUT_SHIFT;
  assign w_pos  = w_s > MAXV;
  assign w_neg  = w_s < MINV;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_acc   <= '0;
      r_out_sat   <= 1'b0;
      r_lo        <= '0;
      r_c         <= 1'b0;
      r_sum_hi    <= '0;
      r_cout_hi   <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        {r_c, r_lo} <= w_lo;
        r_sum_hi    <= in_sum[PW-1:W];
        r_cout_hi   <= w_csh[PW-1:W];
        r_first     <= in_first;
        r_last      <= in_last;
      end
      if (r_s1_valid) r_acc <= w_new;
      // en implies any pending result is being taken, so valid tracks only a new capture
      r_out_valid <= r_s1_valid && r_last;
      if (r_s1_valid && r_last) begin
        r_out_acc  <= w_new;
        r_out_data <= w_pos ? {1'b0, {(W-1){1'b1}}} : w_neg ? {1'b1, {(W-1){1'b0}}} : w_s[W-1:0];
        r_out_sat  <= w_pos || w_neg;
      end
    end
  end
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_acc   = r_out_acc;
  assign out_sat   = r_out_sat;
endmodule
